seq_pattern_tx: RTL and testbench

- Serial pattern transmitter: the driving end for the team's serial sequence-detector FSMs.
- On a start request it latches a parallel pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, on a single-bit `out` line.
- It can repeat the pattern with an optional idle gap between frames, so a detector bench can be driven by RTL instead of hand-timed delays.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/piso_shift.sv | 35 +++
 rtl/seq_pattern_tx.sv | 173 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the serial pattern transmitter and the
// sequence-detector FSMs it drives.
//   - state_t : common 2-bit state encoding, so that waveforms from the
//               transmitter and the detectors decode the same way.
//   - clog2   : ceiling log2, used for sizing counters at elaboration.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift: WIDTH-bit parallel-in serial-out shift register, MSB first.
//   clk      : rising-edge clock
//   rst      : synchronous reset, active low (clears the register)
//   load     : load din into the register (takes priority over shift_en)
//   shift_en : shift left by one, filling with 0
//   din      : parallel data to load
//   sout     : current MSB of the register (registered)
// Shifting in zeros means the register drains to all-zero after WIDTH
// shifts, so sout idles low without any extra gating.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_reg <= '0;
    end else if (load) begin
      sreg_reg <= din;
    end else if (shift_en) begin
      sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = sreg_reg[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. On an accepted start it
// latches pattern/repeat_n and sends repeat_n+1 frames of the pattern,
// MSB first, one bit per clock, with GAP idle cycles between frames.
//   clk       : rising-edge clock
//   rst       : synchronous reset, active low
//   start     : request to send, only looked at in IDLE
//   pattern   : WIDTH bits to send, latched on acceptance
//   repeat_n  : number of extra frames (total frames = repeat_n+1)
//   out       : serial data, 0 whenever out_valid is low
//   out_valid : high on every cycle out carries a pattern bit
//   busy      : high from the cycle after acceptance through DONE
//   done      : one-cycle pulse after the last bit of the last frame
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = clog2(WIDTH);
  // The gap counter keeps at least one bit so the design elaborates for
  // GAP of 0 or 1; it is simply never advanced past 0 in those cases.
  localparam int GW = (GAP > 1) ? clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic [GW-1:0]    gap_cnt_reg;
  logic [REP_W-1:0] frames_left_reg;
  logic [WIDTH-1:0] pat_copy_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             accept;
  logic             bit_last;
  logic             gap_last;
  logic             more_frames;
  logic             piso_load;
  logic             piso_shift_en;
  logic [WIDTH-1:0] piso_din;

  // Shift-register control. The register is loaded one edge before the
  // first bit of every frame: on acceptance, on the last gap cycle, or on
  // the last bit of a frame when frames run back-to-back. Repeated frames
  // come from the latched copy so later input changes cannot leak in.
  always_comb begin
    accept        = (state_reg == S_IDLE) && start;
    bit_last      = (bit_cnt_reg == BIT_LAST);
    gap_last      = (gap_cnt_reg == GAP_LAST);
    more_frames   = (frames_left_reg != '0);
    piso_load     = accept
                  || ((state_reg == S_GAP) && gap_last)
                  || ((state_reg == S_SHIFT) && bit_last && more_frames && (GAP == 0));
    piso_shift_en = (state_reg == S_SHIFT);
    piso_din      = accept ? pattern : pat_copy_reg;
  end

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load),
    .shift_en (piso_shift_en),
    .din      (piso_din),
    .sout     (out)
  );

  // Control FSM. Output registers are written with the value they must
  // show in the state being entered, so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      bit_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      frames_left_reg <= '0;
      pat_copy_reg    <= '0;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          if (start) begin
            pat_copy_reg    <= pattern;
            frames_left_reg <= repeat_n;
            bit_cnt_reg     <= '0;
            out_valid_reg   <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          busy_reg <= 1'b1;
          if (bit_last) begin
            bit_cnt_reg <= '0;
            if (more_frames) begin
              frames_left_reg <= frames_left_reg - 1'b1;
              if (GAP == 0) begin
                out_valid_reg <= 1'b1;
                state_reg     <= S_SHIFT;
              end else begin
                gap_cnt_reg   <= '0;
                out_valid_reg <= 1'b0;
                state_reg     <= S_GAP;
              end
            end else begin
              out_valid_reg <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= S_DONE;
            end
          end else begin
            bit_cnt_reg   <= bit_cnt_reg + 1'b1;
            out_valid_reg <= 1'b1;
          end
        end

        S_GAP: begin
          busy_reg <= 1'b1;
          if (gap_last) begin
            gap_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= S_SHIFT;
          end else begin
            gap_cnt_reg   <= gap_cnt_reg + 1'b1;
            out_valid_reg <= 1'b0;
          end
        end

        S_DONE: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          bit_cnt_reg   <= '0;
          gap_cnt_reg   <= '0;
          state_reg     <= S_IDLE;
        end

        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          bit_cnt_reg   <= '0;
          gap_cnt_reg   <= '0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx (WIDTH=8, GAP=2, REP_W=4).
// Stimulus pushes expected (bit, cycle) entries, done cycles and detector
// hit cycles into queues; a negedge monitor pops and compares whenever the
// DUT presents out_valid, done, or the loopback 1011 detector fires.
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [REP_W-1:0] repeat_n = '0;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  seq_pattern_tx #(
    .WIDTH (WIDTH),
    .GAP   (GAP),
    .REP_W (REP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .repeat_n  (repeat_n),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic b;
    int   at;
  } bit_t;

  bit_t exp_bits[$];
  int   exp_done[$];
  int   exp_det[$];

  // Loopback 1011 detector, overlapping, registered hit one cycle after
  // the final '1'. Only looks at valid bits; cleared while det_arm is low.
  logic       det_arm = 1'b0;
  logic [3:0] hist;
  logic       det;
  always @(posedge clk) begin
    if (!det_arm) begin
      hist <= 4'd0;
      det  <= 1'b0;
    end else begin
      det <= 1'b0;
      if (out_valid === 1'b1) begin
        hist <= {hist[2:0], out};
        det  <= ({hist[2:0], out} == 4'b1011);
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    bit_t e;
    int   d;
    if (out_valid === 1'b1) begin
      total++;
      if (exp_bits.size() == 0) begin
        bad++;
        $display("FAIL extra_bit: cyc=%0d out=%0b but no bit expected", cyc, out);
      end else begin
        e = exp_bits.pop_front();
        if (out !== e.b || cyc != e.at) begin
          bad++;
          $display("FAIL bit: got out=%0b at cyc=%0d, need out=%0b at cyc=%0d", out, cyc, e.b, e.at);
        end
      end
    end else if (out_valid === 1'b0) begin
      total++;
      if (out !== 1'b0) begin
        bad++;
        $display("FAIL out_idle: cyc=%0d out=%0b need 0 while out_valid=0", cyc, out);
      end
    end
    if (done === 1'b1) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL extra_done: done at cyc=%0d with none expected", cyc);
      end else begin
        d = exp_done.pop_front();
        if (cyc != d || busy !== 1'b1) begin
          bad++;
          $display("FAIL done: got done at cyc=%0d busy=%0b, need cyc=%0d busy=1", cyc, busy, d);
        end
      end
    end
    if (det === 1'b1) begin
      total++;
      if (exp_det.size() == 0) begin
        bad++;
        $display("FAIL extra_det: detector hit at cyc=%0d with none expected", cyc);
      end else begin
        d = exp_det.pop_front();
        if (cyc != d) begin
          bad++;
          $display("FAIL det: detector hit at cyc=%0d, need cyc=%0d", cyc, d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h need %0h (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  // Push the full expected response of a transfer accepted at the edge
  // following negedge cycle c.
  task automatic push_transfer(input logic [WIDTH-1:0] p, input int rn, input int c);
    for (int f = 0; f <= rn; f++)
      for (int k = 0; k < WIDTH; k++) begin
        bit_t e;
        e.b  = p[WIDTH-1-k];
        e.at = c + 1 + f * (WIDTH + GAP) + k;
        exp_bits.push_back(e);
      end
    exp_done.push_back(c + 1 + (rn + 1) * WIDTH + rn * GAP);
  endtask

  // Issue a start pulse at the next negedge; returns that cycle number.
  task automatic pulse_start(input logic [WIDTH-1:0] p, input int rn, output int c);
    @(negedge clk);
    start    = 1'b1;
    pattern  = p;
    repeat_n = REP_W'(rn);
    c        = cyc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Count busy cycles starting at the negedge after acceptance (already
  // consumed by pulse_start, where busy must be high) until busy drops.
  task automatic count_busy(input string name, input int want);
    int n;
    int guard;
    n = 1;
    guard = 0;
    while (busy === 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) n++;
    end
    if (guard >= 1000) begin
      bad++;
      total++;
      $display("FAIL %s_timeout: busy never dropped", name);
    end else begin
      check(name, n, want);
    end
  endtask

  initial begin
    int c;
    // Reset held with start high: nothing may start.
    rst   = 1'b0;
    start = 1'b1;
    pattern = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    $display("txn reset: outputs idle through reset");

    // Single frame
    pulse_start(8'b1011_0010, 0, c);
    push_transfer(8'b1011_0010, 0, c);
    check("single_busy_first", busy, 1);
    count_busy("single_busy_cycles", WIDTH + 1);
    $display("txn single: pattern=b2 repeat_n=0 start_cyc=%0d", c);

    // Repeat with gap
    repeat (2) @(negedge clk);
    pulse_start(8'hA5, 2, c);
    push_transfer(8'hA5, 2, c);
    count_busy("repeat_busy_cycles", 3 * WIDTH + 2 * GAP + 1);
    $display("txn repeat: pattern=a5 repeat_n=2 start_cyc=%0d", c);

    // Ignored start and input change during first frame
    repeat (2) @(negedge clk);
    pulse_start(8'h3C, 1, c);
    push_transfer(8'h3C, 1, c);
    @(negedge clk);
    start = 1'b1; pattern = 8'hFF; repeat_n = 4'd5;
    @(negedge clk);
    start = 1'b0;
    count_busy("ignore_busy_rest", 2 * WIDTH + GAP + 1 - 2);
    repeat (20) @(negedge clk);
    check("ignore_no_second", busy, 0);
    $display("txn ignore: pattern=3c repeat_n=1 with stray start/pattern=ff");

    // Reset mid-operation at bit 4 of frame 1
    pulse_start(8'hC3, 3, c);
    for (int k = 0; k < 4; k++) begin
      bit_t e;
      e.b  = 8'hC3 >> (WIDTH - 1 - k);
      e.at = c + 1 + k;
      exp_bits.push_back(e);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out", out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_quiet", busy, 0);
    pulse_start(8'h96, 0, c);
    push_transfer(8'h96, 0, c);
    count_busy("midrst_fresh_busy", WIDTH + 1);
    $display("txn midreset: transfer aborted, fresh pattern=96 sent");

    // Loopback into 1011 detector
    repeat (2) @(negedge clk);
    det_arm = 1'b1;
    @(negedge clk);
    pulse_start(8'b0101_1011, 1, c);
    push_transfer(8'b0101_1011, 1, c);
    for (int f = 0; f < 2; f++) begin
      exp_det.push_back(c + 2 + f * (WIDTH + GAP) + 4);
      exp_det.push_back(c + 2 + f * (WIDTH + GAP) + 7);
    end
    count_busy("loop_busy_cycles", 2 * WIDTH + GAP + 1);
    repeat (3) @(negedge clk);
    det_arm = 1'b0;
    $display("txn loopback: pattern=5b repeat_n=1 into 1011 detector");

    repeat (5) @(negedge clk);
    check("left_bits", exp_bits.size(), 0);
    check("left_done", exp_done.size(), 0);
    check("left_det", exp_det.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
